// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared glyph table, digit-select encoding and segment ordering
// Used by both the capture path and the seven-segment driver so both agree on glyphs.
package seven_segment_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    // Segment bit positions within the segment bus (1 = lit).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic DIGIT_LO = 1'b0;
    localparam logic DIGIT_HI = 1'b1;

    typedef enum logic [1:0] {
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_PUBLISH
    } cap_state_e;

    function automatic logic [SEG_W-1:0] glyph_of(input logic [NIBBLE_W-1:0] n);
        logic [SEG_W-1:0] g;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_to_nibble.sv
// rtl/seg_to_nibble.sv - combinational reverse lookup from segment pattern to hex nibble
module seg_to_nibble
    import seven_segment_pkg::*;
#(
    parameter int DW = 7
) (
    input  logic [DW-1:0]       seg,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                legal
);

    always_comb begin
        nibble = '0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == DW'(glyph_of(NIBBLE_W'(i)))) begin
                nibble = NIBBLE_W'(i);
                legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - recovers a two-digit hex word from an observed multiplexed display
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 7,
    parameter int SETTLE = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] led_port,
    input  logic          c,
    output logic [AW-1:0] data,
    output logic          valid,
    output logic          err
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [DW:0]           r_sample;
    logic [CW-1:0]         r_cnt;
    logic [NIBBLE_W-1:0]   r_nib_lo;
    logic [NIBBLE_W-1:0]   r_nib_hi;
    logic [1:0]            r_filled;
    logic                  r_first;
    logic                  r_err;
    logic [AW-1:0]         r_data;
    cap_state_e            r_state;
    cap_state_e            w_state_nxt;

    logic                  w_same;
    logic                  w_capture;
    logic                  w_sel;
    logic [NIBBLE_W-1:0]   w_nibble;
    logic                  w_legal;
    logic                  w_cap_legal;
    logic [1:0]            w_filled_nxt;
    logic [NIBBLE_W-1:0]   w_nib_lo_nxt;
    logic [NIBBLE_W-1:0]   w_nib_hi_nxt;
    logic                  w_pair_done;
    logic [AW-1:0]         w_assembled;
    logic                  w_publish;

    seg_to_nibble #(.DW(DW)) u_seg_to_nibble (
        .seg    (r_sample[DW-1:0]),
        .nibble (w_nibble),
        .legal  (w_legal)
    );

    // A change on the edge that would complete settling wins: no capture.
    assign w_same      = ({c, led_port} == r_sample);
    assign w_capture   = w_same && (r_cnt == CW'(SETTLE - 1));
    assign w_sel       = r_sample[DW];
    assign w_cap_legal = w_capture && w_legal;

    always_comb begin
        w_filled_nxt = r_filled;
        w_nib_lo_nxt = r_nib_lo;
        w_nib_hi_nxt = r_nib_hi;
        if (w_cap_legal) begin
            w_filled_nxt[w_sel] = 1'b1;
            if (w_sel == DIGIT_LO) w_nib_lo_nxt = w_nibble;
            else                   w_nib_hi_nxt = w_nibble;
        end
    end

    assign w_pair_done = w_cap_legal && (&w_filled_nxt);
    assign w_assembled = AW'({w_nib_hi_nxt, w_nib_lo_nxt});
    assign w_publish   = w_pair_done && (r_first || (w_assembled != r_data));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample <= '0;
            r_cnt    <= '0;
            r_nib_lo <= '0;
            r_nib_hi <= '0;
            r_filled <= '0;
            r_first  <= 1'b1;
            r_err    <= 1'b0;
            r_data   <= '0;
        end else begin
            r_sample <= {c, led_port};
            if (!w_same)                    r_cnt <= '0;
            else if (r_cnt != CW'(SETTLE))  r_cnt <= r_cnt + 1'b1;
            r_nib_lo <= w_nib_lo_nxt;
            r_nib_hi <= w_nib_hi_nxt;
            r_filled <= w_pair_done ? 2'b00 : w_filled_nxt;
            r_err    <= w_capture && !w_legal;
            if (w_publish) begin
                r_data  <= w_assembled;
                r_first <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_WAIT_LO;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = ST_WAIT_LO;
        if (w_publish)                     w_state_nxt = ST_PUBLISH;
        else if (w_pair_done)              w_state_nxt = ST_WAIT_LO;
        else if (w_filled_nxt[DIGIT_LO])   w_state_nxt = ST_WAIT_HI;
    end

    always_comb begin
        valid = (r_state == ST_PUBLISH);
        err   = r_err;
        data  = r_data;
    end

endmodule

// File: doc/seven_segment_capture.md
SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

Interface
REQ-001 Parameter AW, default 8, SHALL set the width of the recovered data word (two hex digits).
REQ-002 Parameter DW, default 7, SHALL set the segment bus width, with bit0=a through bit6=g, where 1 = segment lit.
REQ-003 Parameter SETTLE, default 16, legal range >= 1, SHALL set the number of consecutive stable clock edges required before a digit is captured.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 led_port  input  DW  SHALL carry the observed segment pattern.
REQ-007 c  input  1  SHALL be the observed digit select: 0 = low nibble digit, 1 = high nibble digit.
REQ-008 data  output  AW  SHALL hold the last published value: {high nibble, low nibble}.
REQ-009 valid  output  1  SHALL pulse high for one cycle when data is updated.
REQ-010 err  output  1  SHALL pulse high for one cycle when a stable pattern is not a legal hex glyph.

Function
REQ-011 The block SHALL register {c, led_port} and compare it each cycle with the previous sample; any difference SHALL clear the settle counter to 0.
REQ-012 An unchanged sample SHALL increment the settle counter, saturating at SETTLE.
REQ-013 On the edge where the counter reaches SETTLE, the block SHALL decode led_port exactly once; no re-capture SHALL occur until a change is seen.
REQ-014 The glyph table SHALL map 0..F to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex, bit0=a); any other pattern SHALL be illegal.
REQ-015 A legal capture SHALL write the nibble into slot c and set that slot's filled flag; an illegal capture SHALL assert err and leave the slot and its flag unchanged.
REQ-016 Re-capturing an already filled slot SHALL overwrite its nibble.
REQ-017 When both filled flags become set, the block SHALL, on that same edge, load data, pulse valid, and clear both flags.
REQ-018 valid SHALL NOT pulse if the assembled value equals the currently published data, except for the first publish after reset.
REQ-019 A change on the same edge that the counter would reach SETTLE SHALL take precedence: the counter clears and no capture occurs.
REQ-020 valid and err SHALL never be high for more than one consecutive cycle per capture event.
REQ-021 The state machine SHALL have three states: WAIT_LO/WAIT_HI (at least one slot empty) and PUBLISH (transient, one cycle), entered when both flags are set and returning to the empty-slot state with both flags cleared.

Reset
REQ-022 While reset=0, the following SHALL hold asynchronously: data=0, valid=0, err=0, settle counter=0, both filled flags=0, first-publish flag set, sampled input register=0.
REQ-023 Reset asserted mid-settle or mid-pair SHALL discard partial captures; after release, SETTLE new stable edges SHALL be required.

Structure
REQ-024 The glyph table, the digit-select encoding (LO=0, HI=1), and the segment bit ordering SHALL live in the shared package seven_segment_pkg, which is also used by seven_segment_decoder.
REQ-025 Glyph-to-nibble lookup SHALL be the combinational sub-module seg_to_nibble (outputs: nibble, legal).
REQ-026 The settle counter width SHALL be $clog2(SETTLE+1).

Verification
REQ-027 SETTLE=4: hold c=0/led=06 for 4 edges, then c=1/led=5B for 4 edges -> one valid pulse with data=8'h21.
REQ-028 Drive the 8'h21 pair again, unchanged -> no valid pulse; then drive c=0/led=7F -> valid with data=8'h28.
REQ-029 Hold c=1/led=7E (illegal) for 4 edges -> err pulses once, valid stays 0, and the slot stays empty.
REQ-030 Toggle led every 3 edges with SETTLE=4 -> no capture, no valid, no err.
REQ-031 Assert reset after the low digit is captured -> all outputs 0; a subsequent full pair 71/39 -> data=8'hCF.
REQ-032 Loop back from seven_segment_decoder (refresh slowed so that each digit is held for at least SETTLE cycles) with addr=8'h0F -> data=8'h0F and valid pulses once.
